// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer that owns the Hi/Lo register pair.
// A radix-2 shift-add multiplier and a restoring divider share one
// 2*DATA_W working register (p_hi:p_lo). Signed operands are reduced to
// magnitudes at accept time, and a single FIX cycle restores the signs.
module muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              hilo_rd,
    input  logic              kill,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_ACC} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic               sign_a, sign_b, dz;
    logic [DATA_W-1:0]  a_q, b_q, p_hi, p_lo;

    // Decode of the op being presented, and of the op in flight
    logic               in_signed, in_div, in_mt;
    logic               q_div, q_acc, last_iter;
    logic [DATA_W-1:0]  rs_mag, rt_mag;
    logic               accept, hilo_we;

    assign in_signed = (op == OP_MULT) || (op == OP_DIV) ||
                       (op == OP_MADD) || (op == OP_MSUB);
    assign in_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign in_mt     = (op == OP_MTHI) || (op == OP_MTLO);
    assign rs_mag    = (in_signed && rs_val[DATA_W-1]) ? -rs_val : rs_val;
    assign rt_mag    = (in_signed && rt_val[DATA_W-1]) ? -rt_val : rt_val;

    assign q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign q_acc     = (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    assign busy  = (state != S_IDLE);
    assign stall = busy & (start | hilo_rd);

    // Iteration datapath and sign fixup terms
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ge, neg;
    logic [2*DATA_W-1:0] prod_fix, acc_sum;
    logic [DATA_W-1:0]   q_fix, r_fix;

    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
    // Remainder stays below the divisor, so one extra bit holds the shifted value
    assign div_shift = {p_hi, p_lo[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift - {1'b0, b_q};
    assign neg       = sign_a ^ sign_b;
    assign prod_fix  = neg ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign q_fix     = neg ? -p_lo : p_lo;
    assign r_fix     = sign_a ? -p_hi : p_hi;
    assign acc_sum   = (op_q == OP_MSUB) ? ({Hi, Lo} - {p_hi, p_lo})
                                         : ({Hi, Lo} + {p_hi, p_lo});

    // State register
    always_ff @(posedge Clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state, accept and Hi/Lo write-enable decode
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        hilo_we = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !kill) begin
                    accept = 1'b1;
                    if (in_mt)       hilo_we = 1'b1;
                    else if (in_div) state_n = (rt_val == '0) ? S_FIX : S_DIV;
                    else             state_n = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (kill)           state_n = S_IDLE;
                else if (last_iter) state_n = S_FIX;
            end
            S_FIX: begin
                if (kill)       state_n = S_IDLE;
                else if (q_acc) state_n = S_ACC;
                else begin
                    state_n = S_IDLE;
                    hilo_we = 1'b1;
                end
            end
            S_ACC: begin
                state_n = S_IDLE;
                hilo_we = !kill;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operand capture, iteration, fixup and Hi/Lo update
    always_ff @(posedge Clk) begin
        if (reset) begin
            done   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
            cnt    <= '0;
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
        end else begin
            done <= hilo_we;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI)      Hi <= rs_val;
                        else if (op == OP_MTLO) Lo <= rs_val;
                        else begin
                            op_q   <= op;
                            cnt    <= '0;
                            sign_a <= in_signed & rs_val[DATA_W-1];
                            sign_b <= in_signed & rt_val[DATA_W-1];
                            dz     <= in_div && (rt_val == '0);
                            p_hi   <= '0;
                            b_q    <= rt_mag;
                            if (in_div) begin
                                // raw dividend kept for the divide-by-zero result
                                a_q  <= rs_val;
                                p_lo <= rs_mag;
                            end else begin
                                a_q  <= rs_mag;
                                p_lo <= rt_mag;
                            end
                        end
                    end
                end
                S_MUL: begin
                    p_hi <= mul_sum[DATA_W:1];
                    p_lo <= {mul_sum[0], p_lo[DATA_W-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    p_hi <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                    p_lo <= {p_lo[DATA_W-2:0], div_ge};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!kill) begin
                        if (dz) begin
                            Hi <= a_q;
                            Lo <= '1;
                        end else if (q_div) begin
                            Hi <= r_fix;
                            Lo <= q_fix;
                        end else if (q_acc) begin
                            {p_hi, p_lo} <= prod_fix;
                        end else begin
                            {Hi, Lo} <= prod_fix;
                        end
                    end
                end
                S_ACC: begin
                    if (!kill) {Hi, Lo} <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic
// reference model of the Hi/Lo results and the busy latency.
module tb_muldiv_sequencer;
    logic        Clk = 1'b0;
    logic        reset, start, hilo_rd, kill;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall, done;
    logic [31:0] Hi, Lo;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] m_hl;

    always #5 Clk = ~Clk;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_rd(hilo_rd), .kill(kill),
        .busy(busy), .stall(stall), .done(done), .Hi(Hi), .Lo(Lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {Hi,Lo} after op o, computed with plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint sa, sb, sp;
        longint unsigned ua, ub;
        int ia, ib, iq, ir;
        logic [63:0] r;
        sa = $signed(a); sb = $signed(b); sp = sa * sb;
        ua = a; ub = b;
        r = hl;
        case (o)
            3'd0: r = sp;
            3'd1: r = ua * ub;
            3'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    ia = a; ib = b; iq = ia / ib; ir = ia % ib;
                    r = {ir, iq};
                end
            end
            3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'd4: r = hl + sp;
            3'd5: r = hl - sp;
            3'd6: r = {a, hl[31:0]};
            default: r = {hl[63:32], a};
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd6 || o == 3'd7) return 0;
        if ((o == 3'd2 || o == 3'd3) && b == 0) return 1;
        if (o == 3'd4 || o == 3'd5) return 34;
        return 33;
    endfunction

    // Called at the negedge right after the accept edge; counts busy cycles
    task automatic wait_done(input string tag, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        exp = model(o, a, b, m_hl);
        start = 1'b0; hilo_rd = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge Clk);
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat(o, b)));
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(Hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(Lo), 64'(exp[31:0]));
        m_hl = exp;
    endtask

    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge Clk);
        wait_done(tag, o, a, b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int n;
        reset = 1'b1; start = 1'b0; hilo_rd = 1'b0; kill = 1'b0;
        op = 3'd0; rs_val = '0; rt_val = '0;
        m_hl = '0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);

        // Directed cases
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("multu_const", {32'(Hi), 32'(Lo)}, 64'h0000_0001_FFFF_FFFE);
        do_op("mult", 3'd0, -32'sd3, 32'd5);
        chk("mult_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("div", 3'd2, -32'sd7, 32'd2);
        chk("div_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {32'(Hi), 32'(Lo)}, 64'h0000_0000_8000_0000);
        do_op("mtlo", 3'd7, 32'd5, 32'd0);
        do_op("mthi", 3'd6, 32'd0, 32'd0);
        do_op("madd", 3'd4, 32'd3, 32'd4);
        chk("madd_const", {32'(Hi), 32'(Lo)}, 64'h0000_0000_0000_0011);
        do_op("msub", 3'd5, 32'd2, 32'd9);
        chk("msub_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Divide by zero with a Hi/Lo read while busy
        @(negedge Clk);
        start = 1'b1; op = 3'd3; rs_val = 32'h1234; rt_val = '0;
        @(negedge Clk);
        start = 1'b0; hilo_rd = 1'b1;
        #1 chk("dz_stall", 64'(stall), 64'd1);
        wait_done("divu0", 3'd3, 32'h1234, 32'd0);
        chk("divu0_const", {32'(Hi), 32'(Lo)}, 64'h0000_1234_FFFF_FFFF);

        // Back-to-back: second op and read held during busy
        @(negedge Clk);
        start = 1'b1; op = 3'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
        @(negedge Clk);
        op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; hilo_rd = 1'b1;
        n = 1;
        @(negedge Clk);
        while (busy && n < 200) begin
            chk("b2b_stall", 64'(stall), 64'd1);
            n++;
            @(negedge Clk);
        end
        chk("b2b_lat", 64'(n), 64'd33);
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_nostall", 64'(stall), 64'd0);
        chk("b2b_hilo", {32'(Hi), 32'(Lo)}, 64'h0000_0001_FFFF_FFFE);
        m_hl = 64'h0000_0001_FFFF_FFFE;
        @(negedge Clk);
        wait_done("b2b_2nd", 3'd3, 32'd100, 32'd7);

        // Kill mid-divide leaves Hi/Lo alone and gives no done
        do_op("mthi_a", 3'd6, 32'hA, 32'd0);
        do_op("mtlo_b", 3'd7, 32'hB, 32'd0);
        @(negedge Clk);
        start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        kill = 1'b1;
        @(negedge Clk);
        kill = 1'b0;
        chk("kill_busy", 64'(busy), 64'd0);
        chk("kill_done", 64'(done), 64'd0);
        chk("kill_hilo", {32'(Hi), 32'(Lo)}, 64'h0000_000A_0000_000B);
        @(negedge Clk);
        chk("kill_done2", 64'(done), 64'd0);

        // Kill with start in IDLE blocks an MTHI
        start = 1'b1; kill = 1'b1; op = 3'd6; rs_val = 32'h55;
        @(negedge Clk);
        start = 1'b0; kill = 1'b0;
        chk("killmt_done", 64'(done), 64'd0);
        chk("killmt_hi", 64'(Hi), 64'hA);

        // Reset in the middle of a multiply
        start = 1'b1; op = 3'd0; rs_val = 32'd77; rt_val = 32'd99;
        @(negedge Clk);
        start = 1'b0;
        repeat (19) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {32'(Hi), 32'(Lo)}, 64'd0);
        m_hl = '0;
        @(negedge Clk);
        chk("midrst_done", 64'(done), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op("rand", ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
